// File: rtl/led_pkg.sv
// Shared definitions for the NeoPixel frame scheduler.
// Contents: FSM state encoding, GRB/RAM word widths and two small helpers
// used when latching the bit timings.
package led_pkg;

  localparam int GRB_BITS   = 24;
  localparam int RAM_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } led_state_e;

  // A zero timing count would stall the down-counter terminal compare,
  // so it is promoted to the shortest legal phase.
  function automatic logic [7:0] clamp_time(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_bit_shifter.sv
// Per-channel GRB serializer.
// Holds one 24-bit GRB word, shifts it MSB-first, and decides when this
// channel's line drops during the shared high phase.
// Ports:
//   clk_i, rst_i  clock / synchronous active-high reset
//   load          capture word (start of an LED)
//   shift         advance to the next bit
//   word          GRB word from this channel's RAM bank
//   elapsed       cycles spent so far in the current high phase
//   t0h, t1h      latched high times for a 0 / 1 bit
//   high_phase    FSM is in its high phase
//   msb           current bit being sent
//   line          serial output for this channel
module led_bit_shifter
  import led_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load,
  input  logic                shift,
  input  logic [GRB_BITS-1:0] word,
  input  logic [7:0]          elapsed,
  input  logic [7:0]          t0h,
  input  logic [7:0]          t1h,
  input  logic                high_phase,
  output logic                msb,
  output logic                line
);

  logic [GRB_BITS-1:0] sr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr <= '0;
    end else if (load) begin
      sr <= word;
    end else if (shift) begin
      sr <= {sr[GRB_BITS-2:0], 1'b0};
    end
  end

  assign msb  = sr[GRB_BITS-1];
  // The shared high phase lasts max(t0h,t1h); this channel stays high only
  // for the high time matching its own current bit.
  assign line = high_phase && (elapsed < (msb ? t1h : t0h));

endmodule

// File: rtl/led_scan_ctrl.sv
// NeoPixel frame scheduler.
// On start_i, walks the color RAM once, serializes each channel's GRB word
// on data_o with the latched T0H/T0L/T1H/T1L counts, then holds the lines
// low for RST_CNT cycles and pulses done_o.
// Ports:
//   clk_i, rst_i          clock / synchronous active-high reset
//   start_i               frame start request
//   t0h_i..t1l_i          bit timing counts in clk_i cycles
//   rd_en_o, rd_addr_o    shared RAM read strobe / word address
//   rd_data_i             CH_NUM x 32-bit read data, 1-cycle latency
//   data_o                serial NeoPixel lines
//   busy_o, done_o        frame in progress / end-of-frame pulse
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | RAM read for the current LED
// LOAD  | capture read data into the shifters
// HIGH  | lines high, each drops after its own high time
// LOW   | lines low for max low time, then next bit / LED
// LATCH | lines low for RST_CNT cycles, then done_o
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int LED_NUM = 64,
  parameter int ADDR_W  = 6,
  parameter int RST_CNT = 4000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [7:0]                 t0h_i,
  input  logic [7:0]                 t0l_i,
  input  logic [7:0]                 t1h_i,
  input  logic [7:0]                 t1l_i,
  output logic                       rd_en_o,
  output logic [ADDR_W-1:0]          rd_addr_o,
  input  logic [CH_NUM*RAM_WORD_W-1:0] rd_data_i,
  output logic [CH_NUM-1:0]          data_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int                LAT_W    = $clog2(RST_CNT + 1);
  localparam logic [ADDR_W-1:0] LED_LAST = ADDR_W'(LED_NUM - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RST_CNT);

  led_state_e state, next_state;

  logic [7:0]        t0h_q, t0l_q, t1h_q, t1l_q;
  logic [7:0]        max_h, max_l;
  logic [7:0]        tmr;
  logic [7:0]        elapsed;
  logic              tmr_last;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-1:0] led_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_last;
  logic              sr_load, sr_shift, high_phase;
  logic [CH_NUM-1:0] msb;

  assign max_h    = max8(t0h_q, t1h_q);
  assign max_l    = max8(t0l_q, t1l_q);
  assign tmr_last = (tmr == 8'd1);
  // tmr counts max_h..1 during HIGH, so elapsed runs 0..max_h-1.
  assign elapsed  = max_h - tmr;
  assign lat_last = (lat_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_i) next_state = READ;
      READ:  next_state = LOAD;
      LOAD:  next_state = HIGH;
      HIGH:  if (tmr_last) next_state = LOW;
      LOW: begin
        if (tmr_last) begin
          if (bit_cnt != 5'd0)       next_state = HIGH;
          else if (led_cnt == LED_LAST) next_state = LATCH;
          else                       next_state = READ;
        end
      end
      LATCH: if (lat_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_en_o    = (state == READ);
    high_phase = (state == HIGH);
    sr_load    = (state == LOAD);
    sr_shift   = (state == LOW) && tmr_last && (bit_cnt != 5'd0);
    done_o     = (state == LATCH) && lat_last;
    busy_o     = (state != IDLE) && !done_o;
  end

  // led_cnt only changes on entry to READ, so it doubles as the held address.
  assign rd_addr_o = led_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t0h_q   <= 8'd1;
      t0l_q   <= 8'd1;
      t1h_q   <= 8'd1;
      t1l_q   <= 8'd1;
      tmr     <= 8'd0;
      bit_cnt <= 5'd0;
      led_cnt <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            t0h_q   <= clamp_time(t0h_i);
            t0l_q   <= clamp_time(t0l_i);
            t1h_q   <= clamp_time(t1h_i);
            t1l_q   <= clamp_time(t1l_i);
            led_cnt <= '0;
          end
        end
        LOAD: begin
          bit_cnt <= 5'(GRB_BITS - 1);
          tmr     <= max_h;
        end
        HIGH: begin
          if (tmr_last) tmr <= max_l;
          else          tmr <= tmr - 8'd1;
        end
        LOW: begin
          if (tmr_last) begin
            if (bit_cnt != 5'd0) begin
              bit_cnt <= bit_cnt - 5'd1;
              tmr     <= max_h;
            end else if (led_cnt == LED_LAST) begin
              lat_cnt <= LAT_LOAD;
            end else begin
              led_cnt <= led_cnt + 1'b1;
            end
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        LATCH: begin
          if (!lat_last) lat_cnt <= lat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    led_bit_shifter u_shifter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load       (sr_load),
      .shift      (sr_shift),
      .word       (rd_data_i[c*RAM_WORD_W +: GRB_BITS]),
      .elapsed    (elapsed),
      .t0h        (t0h_q),
      .t1h        (t1h_q),
      .high_phase (high_phase),
      .msb        (msb[c]),
      .line       (data_o[c])
    );
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
module tb_led_scan_ctrl;

  localparam int CH = 2;
  localparam int LN = 2;
  localparam int AW = 2;
  localparam int RC = 10;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [7:0]        t0h_i, t0l_i, t1h_i, t1l_i;
  logic              rd_en_o;
  logic [AW-1:0]     rd_addr_o;
  logic [CH*32-1:0]  rd_data_i = '0;
  logic [CH-1:0]     data_o;
  logic              busy_o;
  logic              done_o;

  always #5 clk_i = ~clk_i;

  led_scan_ctrl #(
    .CH_NUM (CH),
    .LED_NUM(LN),
    .ADDR_W (AW),
    .RST_CNT(RC)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .t0h_i    (t0h_i),
    .t0l_i    (t0l_i),
    .t1h_i    (t1h_i),
    .t1l_i    (t1l_i),
    .rd_en_o  (rd_en_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .data_o   (data_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  // Color RAM model with one cycle of read latency.
  logic [CH*32-1:0] mem [LN];
  always @(posedge clk_i) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [CH-1:0] data;
    logic          busy;
    logic          done;
  } obs_t;

  obs_t  exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  string tag      = "reset";

  function automatic int clamp(input logic [7:0] v);
    return (v == 8'd0) ? 1 : int'(v);
  endfunction

  task automatic push(input logic re, input logic [AW-1:0] a, input logic [CH-1:0] d,
                      input logic b, input logic dn);
    obs_t e;
    e.rd_en = re; e.addr = a; e.data = d; e.busy = b; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n, input logic [AW-1:0] a);
    for (int i = 0; i < n; i++) push(1'b0, a, '0, 1'b0, 1'b0);
  endtask

  // Expected per-cycle trace of a whole frame, starting with the READ cycle.
  task automatic build_frame(input logic [7:0] a0h, input logic [7:0] a0l,
                             input logic [7:0] a1h, input logic [7:0] a1l);
    int h0, l0, h1, l1, mh, ml;
    logic [CH*32-1:0] w;
    logic [CH-1:0]    d;
    h0 = clamp(a0h); l0 = clamp(a0l); h1 = clamp(a1h); l1 = clamp(a1l);
    mh = (h0 > h1) ? h0 : h1;
    ml = (l0 > l1) ? l0 : l1;
    for (int led = 0; led < LN; led++) begin
      w = mem[led];
      push(1'b1, AW'(led), '0, 1'b1, 1'b0);
      push(1'b0, AW'(led), '0, 1'b1, 1'b0);
      for (int b = 23; b >= 0; b--) begin
        for (int e = 0; e < mh; e++) begin
          for (int c = 0; c < CH; c++) d[c] = (e < (w[c*32+b] ? h1 : h0));
          push(1'b0, AW'(led), d, 1'b1, 1'b0);
        end
        for (int e = 0; e < ml; e++) push(1'b0, AW'(led), '0, 1'b1, 1'b0);
      end
    end
    for (int i = 0; i < RC; i++) push(1'b0, AW'(LN-1), '0, 1'b1, 1'b0);
    push(1'b0, AW'(LN-1), '0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    obs_t o, e;
    @(negedge clk_i);
    o = {rd_en_o, rd_addr_o, data_o, busy_o, done_o};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s underflow observed=%h expected=none", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h (rd_en,addr,data,busy,done)", tag, o, e);
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  task automatic set_times(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    t0h_i = a; t0l_i = b; t1h_i = c; t1l_i = d;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0;
    set_times(8'd0, 8'd0, 8'd0, 8'd0);
    mem[0] = {32'hAB00_0000, 32'h0080_0000};
    mem[1] = {32'h12FF_0001, 32'h34A5_3C0F};

    tag = "reset";
    push_idle(2, '0);
    tick(); tick();
    rst_i = 1'b0;
    tag = "idle_no_start";
    push_idle(20, '0);
    drain();

    tag = "frame_basic";
    set_times(8'd1, 8'd2, 8'd2, 8'd1);
    start_i = 1'b1;
    build_frame(8'd1, 8'd2, 8'd2, 8'd1);
    tick();
    start_i = 1'b0;
    drain();
    tag = "idle_after_frame";
    push_idle(5, AW'(LN-1));
    drain();

    tag = "start_ignored_mid_frame";
    set_times(8'd3, 8'd1, 8'd1, 8'd2);
    start_i = 1'b1;
    build_frame(8'd3, 8'd1, 8'd1, 8'd2);
    tick();
    start_i = 1'b0;
    repeat (40) tick();
    set_times(8'd5, 8'd5, 8'd5, 8'd5);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (exp_q.size() > 1) tick();
    tag = "done_pulse";
    tick();
    tag = "start_in_done_cycle";
    start_i = 1'b1;
    push_idle(1, AW'(LN-1));
    tick();
    start_i = 1'b0;
    push_idle(5, AW'(LN-1));
    drain();

    tag = "zero_timings";
    set_times(8'd0, 8'd0, 8'd0, 8'd0);
    start_i = 1'b1;
    build_frame(8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    start_i = 1'b0;
    drain();
    push_idle(3, AW'(LN-1));
    drain();

    tag = "reset_mid_frame";
    set_times(8'd1, 8'd2, 8'd2, 8'd1);
    start_i = 1'b1;
    build_frame(8'd1, 8'd2, 8'd2, 8'd1);
    tick();
    start_i = 1'b0;
    repeat (76) tick();
    rst_i = 1'b1;
    exp_q.delete();
    push_idle(1, '0);
    tick();
    rst_i = 1'b0;
    tag = "after_reset";
    push_idle(4, '0);
    drain();

    tag = "replay_after_reset";
    start_i = 1'b1;
    build_frame(8'd1, 8'd2, 8'd2, 8'd1);
    tick();
    start_i = 1'b0;
    drain();
    push_idle(3, AW'(LN-1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
